des_cbc: RTL and testbench
==========================

# des_cbc

CBC-mode chaining controller that sits in front of the `des` block cipher core and drives its request interface. It accepts 64-bit plaintext or ciphertext blocks and applies the IV/chaining XOR for CBC encryption or decryption (FIPS 81). It issues one single-block request to the core per block and returns the chained result. The core latency is arbitrary; completion is taken solely from the core's valid flag.

## Interface
- Parameters: none; block and key width fixed at 64, bit 0 = MSB.
- `clk_i  in  1` — clock; the only clock.
- `reset_i  in  1` — synchronous, active-high reset.
- `mode_i  in  1` — 0 = encrypt, 1 = decrypt; latched only when `start_i` is high.
- `start_i  in  1` — qualifies `valid_i`; begins a new chain by loading `iv_i`, `key_i` and `mode_i`.
- `key_i  in  [0:63]` — DES key; latched with `start_i`.
- `iv_i  in  [0:63]` — initialisation vector; latched with `start_i`.
- `data_i  in  [0:63]` — input block.
- `valid_i  in  1` — input block valid; accepted only when `accept_o` = 1.
- `accept_o  out  1` — controller can take a block.
- `data_o  out  [0:63]` — chained output block.
- `valid_o  out  1` — one-cycle pulse, output valid.
- `des_mode_o  out  1`, `des_key_o  out  [0:63]` — latched mode/key driven to the core.
- `des_data_o  out  [0:63]`, `des_valid_o  out  1` — core request; `des_valid_o` is a one-cycle pulse.
- `des_data_i  in  [0:63]`, `des_valid_i  in  1` — core result.

## Operation
- Registers: `chain` (64), `cbuf` (64), `mode_q`, `key_q`, and state ∈ {IDLE, BUSY}.
- IDLE:
  - `accept_o` = 1.
  - On `valid_i`, with `start_i` = 1:
    - `chain_eff` = `iv_i`, then `chain` := `iv_i`.
    - `mode_q` := `mode_i`, `key_q` := `key_i`.
    - The core request uses the new mode and key in the same issue cycle.
  - On `valid_i`, with `start_i` = 0:
    - `chain_eff` = `chain`.
    - `mode_q` and `key_q` are unchanged; changes on `mode_i`/`key_i` are ignored.
  - Encrypt (effective mode 0): `des_data_o` := `data_i` XOR `chain_eff`.
  - Decrypt (effective mode 1): `des_data_o` := `data_i`, and `cbuf` := `data_i`.
  - Next cycle: `des_valid_o` = 1 for exactly one cycle, and state := BUSY.
- BUSY:
  - `accept_o` = 0; `valid_i` is ignored.
  - On `des_valid_i`:
    - Encrypt: `data_o` := `des_data_i`, `chain` := `des_data_i`.
    - Decrypt: `data_o` := `des_data_i` XOR `chain`, `chain` := `cbuf`.
    - Next cycle: `valid_o` = 1 for one cycle, and state := IDLE.
- `des_valid_i` while IDLE is ignored, with no state or output change.
- `des_mode_o` = `mode_q` and `des_key_o` = `key_q` at all times; both are constant while BUSY.
- `data_o` holds its last value until the next result; `des_data_o` holds until the next issue.

## Timing
- Reset values: `chain`, `cbuf`, `key_q`, `des_key_o`, `des_data_o` and `data_o` = 0; `mode_q`/`des_mode_o` = 0; `valid_o` = `des_valid_o` = 0; state IDLE, so `accept_o` = 1.
- Request timing: block accepted at edge T → `des_valid_o` high in cycle T+1.
- Result timing: core result sampled at edge R → `valid_o` high and `data_o` valid in cycle R+1.
- Throughput: `accept_o` returns high in the same cycle as `valid_o`; back-to-back accept is allowed in that cycle.
- Total latency: core latency L + 2 cycles.
- Reset mid-operation:
  - Immediate return to IDLE with all registers at reset values.
  - The in-flight core result arrives in IDLE and is dropped; no `valid_o`.
- `start_i` with `valid_i` = 0 has no effect.
- `valid_i` in the cycle `valid_o` rises is accepted, using the `chain` just updated.

## Test plan
- **Identity core** (core returns `des_data_o` after L = 3 cycles):
  - Stimulus: encrypt, `start_i` with iv = 0x00000000FFFFFFFF, data = 0x1111111111111111.
  - Required response: `data_o` = 0x11111111EEEEEEEE, `valid_o` 5 cycles after accept.
  - Second block 0x1111111111111111 without `start_i` → `data_o` = 0x00000000FFFFFFFF.
- **FIPS 81 encrypt** with the real `des` core:
  - Key 0123456789ABCDEF, IV 1234567890ABCDEF.
  - Plaintext 4E6F772069732074 / 68652074696D6520 / 666F7220616C6C20 → E5C7CDDE872BF27C / 43E934008C389C0F / 683788499A7C05F6.
- **FIPS 81 decrypt**: same key/IV; the three ciphertext blocks decrypt back to the three plaintext blocks, with `mode_i` = 1 only on the first block.
- **Handshake**:
  - `valid_i` held high continuously → exactly one accept per result.
  - `accept_o` = 0 throughout BUSY.
  - Mode/key toggles without `start_i` leave `des_mode_o`/`des_key_o` unchanged.
- **Reset mid-BUSY**:
  - Assert `reset_i` one cycle after `des_valid_o`.
  - The core result arriving later produces no `valid_o`, and all outputs are 0.
  - The next chain (iv 0) works correctly.
- **Spurious core valid**: `des_valid_i` pulsed in IDLE → no `valid_o`, `chain` unchanged.

Source files
------------

// File: rtl/des_cbc.sv
// des_cbc: CBC chaining front end for a single-block DES core.
// Wraps the core request/response handshake with the IV/chain XOR for both directions.
module des_cbc (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        mode_i,
  input  logic        start_i,
  input  logic [0:63] key_i,
  input  logic [0:63] iv_i,
  input  logic [0:63] data_i,
  input  logic        valid_i,
  output logic        accept_o,
  output logic [0:63] data_o,
  output logic        valid_o,
  output logic        des_mode_o,
  output logic [0:63] des_key_o,
  output logic [0:63] des_data_o,
  output logic        des_valid_o,
  input  logic [0:63] des_data_i,
  input  logic        des_valid_i
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nx;
  logic [0:63] chain, chain_nx;
  logic [0:63] cbuf, cbuf_nx;
  logic [0:63] key_q, key_nx;
  logic [0:63] req_nx, out_nx, chain_eff;
  logic        mode_q, mode_nx, mode_eff;
  logic        req_vld_nx, out_vld_nx;

  assign accept_o   = (state == IDLE);
  assign des_mode_o = mode_q;
  assign des_key_o  = key_q;

  always_comb begin
    state_nx   = state;
    chain_nx   = chain;
    cbuf_nx    = cbuf;
    key_nx     = key_q;
    mode_nx    = mode_q;
    req_nx     = des_data_o;
    req_vld_nx = 1'b0;
    out_nx     = data_o;
    out_vld_nx = 1'b0;
    mode_eff   = start_i ? mode_i : mode_q;
    chain_eff  = start_i ? iv_i : chain;

    case (state)
      IDLE: begin
        if (valid_i) begin
          if (start_i) begin
            chain_nx = iv_i;
            mode_nx  = mode_i;
            key_nx   = key_i;
          end
          // Decrypt keeps the ciphertext: it becomes the chain once the result returns.
          if (mode_eff) begin
            req_nx  = data_i;
            cbuf_nx = data_i;
          end else begin
            req_nx  = data_i ^ chain_eff;
          end
          req_vld_nx = 1'b1;
          state_nx   = BUSY;
        end
      end
      BUSY: begin
        if (des_valid_i) begin
          if (mode_q) begin
            out_nx   = des_data_i ^ chain;
            chain_nx = cbuf;
          end else begin
            out_nx   = des_data_i;
            chain_nx = des_data_i;
          end
          out_vld_nx = 1'b1;
          state_nx   = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= IDLE;
      chain       <= '0;
      cbuf        <= '0;
      key_q       <= '0;
      mode_q      <= 1'b0;
      des_data_o  <= '0;
      des_valid_o <= 1'b0;
      data_o      <= '0;
      valid_o     <= 1'b0;
    end else begin
      state       <= state_nx;
      chain       <= chain_nx;
      cbuf        <= cbuf_nx;
      key_q       <= key_nx;
      mode_q      <= mode_nx;
      des_data_o  <= req_nx;
      des_valid_o <= req_vld_nx;
      data_o      <= out_nx;
      valid_o     <= out_vld_nx;
    end
  end

endmodule

// File: tb/tb_des_cbc.sv
// Self-checking bench for des_cbc with a behavioural stand-in core of configurable latency.
// Known-answer table on an identity core, then random CBC traffic against a reference model.
module tb_des_cbc;

  logic        clk = 1'b0;
  logic        reset_i, mode_i, start_i, valid_i;
  logic [63:0] key_i, iv_i, data_i;
  logic        accept_o, valid_o, des_mode_o, des_valid_o;
  logic [63:0] data_o, des_key_o, des_data_o;
  logic [63:0] des_data_i;
  logic        des_valid_i;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  des_cbc dut (
    .clk_i(clk), .reset_i(reset_i), .mode_i(mode_i), .start_i(start_i),
    .key_i(key_i), .iv_i(iv_i), .data_i(data_i), .valid_i(valid_i),
    .accept_o(accept_o), .data_o(data_o), .valid_o(valid_o),
    .des_mode_o(des_mode_o), .des_key_o(des_key_o),
    .des_data_o(des_data_o), .des_valid_o(des_valid_o),
    .des_data_i(des_data_i), .des_valid_i(des_valid_i)
  );

  // Toy invertible block cipher standing in for DES: rotate-left 7 then XOR key.
  function automatic logic [63:0] enc(input logic [63:0] k, input logic [63:0] x);
    return {x[56:0], x[63:57]} ^ k;
  endfunction

  function automatic logic [63:0] dec(input logic [63:0] k, input logic [63:0] y);
    logic [63:0] t;
    t = y ^ k;
    return {t[6:0], t[63:7]};
  endfunction

  bit          ident = 1'b1;
  int          core_lat = 3;
  int          core_cnt = 0;
  logic [63:0] core_res = '0;
  bit          spur = 1'b0;

  always @(posedge clk) begin
    if (des_valid_o) begin
      core_cnt <= core_lat;
      core_res <= ident ? des_data_o :
                  (des_mode_o ? dec(des_key_o, des_data_o) : enc(des_key_o, des_data_o));
    end else if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
    end
  end

  assign des_valid_i = (core_cnt == 1) || spur;
  assign des_data_i  = core_res;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // CBC reference: C_i = E(P_i ^ C_{i-1}); P_i = D(C_i) ^ C_{i-1}.
  logic [63:0] m_chain = '0, m_key = '0;
  bit          m_mode = 1'b0;

  task automatic model_blk(input bit st, input bit md, input logic [63:0] k,
                           input logic [63:0] iv, input logic [63:0] d,
                           output logic [63:0] exp);
    if (st) begin
      m_chain = iv;
      m_key   = k;
      m_mode  = md;
    end
    if (!m_mode) begin
      exp     = enc(m_key, d ^ m_chain);
      m_chain = exp;
    end else begin
      exp     = dec(m_key, d) ^ m_chain;
      m_chain = d;
    end
  endtask

  // One block: wait for accept, present it, then watch the BUSY window until valid_o.
  // lat is the cycle index of valid_o, counting the accept cycle as 0.
  task automatic xfer(input bit st, input bit md, input logic [63:0] k,
                      input logic [63:0] iv, input logic [63:0] d,
                      output logic [63:0] res, output int lat,
                      output bit busy_ok, output bit req_ok,
                      output logic [63:0] kobs, output bit mobs);
    int guard = 0;
    @(negedge clk);
    while (!accept_o && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    start_i = st; mode_i = md; key_i = k; iv_i = iv; data_i = d; valid_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    start_i = 1'($urandom); mode_i = 1'($urandom);
    key_i = {$urandom, $urandom}; iv_i = {$urandom, $urandom}; data_i = {$urandom, $urandom};
    lat = 1; busy_ok = 1'b1; req_ok = 1'b1; res = 'x; kobs = des_key_o; mobs = des_mode_o;
    forever begin
      @(negedge clk);
      if (valid_o) begin
        res = data_o;
        valid_i = 1'b0;
        break;
      end
      if (accept_o) busy_ok = 1'b0;
      if ((lat == 1) != des_valid_o) req_ok = 1'b0;
      if (des_key_o !== kobs || des_mode_o !== mobs) busy_ok = 1'b0;
      // Junk on the input side while BUSY must be ignored.
      valid_i = 1'($urandom); start_i = 1'($urandom); mode_i = 1'($urandom);
      key_i = {$urandom, $urandom}; data_i = {$urandom, $urandom};
      @(posedge clk);
      lat++;
      if (lat > 60) begin
        lat = -1;
        valid_i = 1'b0;
        break;
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " data_o"}, data_o, 64'h0);
    chk({tag, " des_data_o"}, des_data_o, 64'h0);
    chk({tag, " des_key_o"}, des_key_o, 64'h0);
    chk({tag, " des_mode_o"}, 64'(des_mode_o), 64'h0);
    chk({tag, " valid_o"}, 64'(valid_o), 64'h0);
    chk({tag, " des_valid_o"}, 64'(des_valid_o), 64'h0);
    chk({tag, " accept_o"}, 64'(accept_o), 64'h1);
  endtask

  typedef struct {
    bit          st;
    bit          md;
    logic [63:0] key;
    logic [63:0] iv;
    logic [63:0] data;
    logic [63:0] exp;
    logic [63:0] exp_key;
    bit          exp_mode;
  } vec_t;

  vec_t vt[6];

  initial begin
    logic [63:0] res, exp, kobs;
    int          lat, acc, rcv;
    bit          busy_ok, req_ok, mobs, saw, b2b_ok;
    logic [63:0] q[$];

    vt[0] = '{1, 0, 64'h0123456789ABCDEF, 64'h00000000FFFFFFFF, 64'h1111111111111111,
              64'h11111111EEEEEEEE, 64'h0123456789ABCDEF, 0};
    vt[1] = '{0, 0, 64'h0, 64'h0, 64'h1111111111111111,
              64'h00000000FFFFFFFF, 64'h0123456789ABCDEF, 0};
    vt[2] = '{0, 1, 64'hFFFFFFFFFFFFFFFF, 64'h5555555555555555, 64'h0,
              64'h00000000FFFFFFFF, 64'h0123456789ABCDEF, 0};
    vt[3] = '{1, 1, 64'h133457799BBCDFF1, 64'hA5A5A5A5A5A5A5A5, 64'h0123456789ABCDEF,
              64'hA486E0C22C0E684A, 64'h133457799BBCDFF1, 1};
    vt[4] = '{0, 0, 64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFF,
              64'hFEDCBA9876543210, 64'h133457799BBCDFF1, 1};
    vt[5] = '{0, 0, 64'hDEADBEEFDEADBEEF, 64'h0, 64'h0,
              64'hFFFFFFFFFFFFFFFF, 64'h133457799BBCDFF1, 1};

    reset_i = 1'b1; mode_i = 1'b0; start_i = 1'b0; valid_i = 1'b0;
    key_i = '0; iv_i = '0; data_i = '0;
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b0;
    @(negedge clk);
    check_reset_state("reset");

    // Known answers on an identity core with L = 3.
    ident = 1'b1; core_lat = 3;
    for (int i = 0; i < 6; i++) begin
      xfer(vt[i].st, vt[i].md, vt[i].key, vt[i].iv, vt[i].data, res, lat, busy_ok, req_ok, kobs, mobs);
      chk($sformatf("vec%0d data_o", i), res, vt[i].exp);
      chk($sformatf("vec%0d latency", i), 64'(lat), 64'(core_lat + 2));
      chk($sformatf("vec%0d des_key_o", i), kobs, vt[i].exp_key);
      chk($sformatf("vec%0d des_mode_o", i), 64'(mobs), 64'(vt[i].exp_mode));
      chk($sformatf("vec%0d busy window", i), 64'(busy_ok), 64'h1);
      chk($sformatf("vec%0d req pulse", i), 64'(req_ok), 64'h1);
    end

    // Random CBC traffic with random core latency, checked against the model.
    ident = 1'b0;
    for (int i = 0; i < 30; i++) begin
      bit          st, md;
      logic [63:0] k, iv, d;
      core_lat = $urandom_range(1, 6);
      st = (i == 0) ? 1'b1 : ($urandom_range(0, 4) == 0);
      md = 1'($urandom);
      k = {$urandom, $urandom}; iv = {$urandom, $urandom}; d = {$urandom, $urandom};
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        start_i = 1'b1; valid_i = 1'b0; mode_i = ~m_mode;
        iv_i = {$urandom, $urandom}; key_i = {$urandom, $urandom};
      end
      model_blk(st, md, k, iv, d, exp);
      xfer(st, md, k, iv, d, res, lat, busy_ok, req_ok, kobs, mobs);
      chk($sformatf("rnd%0d data_o", i), res, exp);
      chk($sformatf("rnd%0d latency", i), 64'(lat), 64'(core_lat + 2));
      chk($sformatf("rnd%0d des_key_o", i), kobs, m_key);
      chk($sformatf("rnd%0d des_mode_o", i), 64'(mobs), 64'(m_mode));
      chk($sformatf("rnd%0d busy window", i), 64'(busy_ok), 64'h1);
      chk($sformatf("rnd%0d req pulse", i), 64'(req_ok), 64'h1);
    end

    // valid_i held high: one accept per result, next accept in the valid_o cycle.
    core_lat = 2; acc = 0; rcv = 0; b2b_ok = 1'b1;
    @(negedge clk);
    start_i = 1'b0; mode_i = ~m_mode; key_i = ~m_key; data_i = 64'h0F1E2D3C4B5A6978; valid_i = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (i > 0) @(negedge clk);
      if (valid_o) begin
        rcv++;
        chk("b2b data_o", data_o, (q.size() > 0) ? q.pop_front() : 64'hx);
      end
      if (accept_o) begin
        if (acc > 0 && !valid_o) b2b_ok = 1'b0;
        acc++;
        model_blk(1'b0, 1'b0, '0, '0, data_i, exp);
        q.push_back(exp);
      end
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) valid_i = 1'b0;
      if (valid_o) begin
        rcv++;
        chk("b2b data_o", data_o, (q.size() > 0) ? q.pop_front() : 64'hx);
      end
    end
    chk("b2b accepts vs results", 64'(acc), 64'(rcv));
    chk("b2b accept in valid_o cycle", 64'(b2b_ok), 64'h1);
    chk("b2b accept count", 64'(acc), 64'(60 / (core_lat + 2)));

    // Reset one cycle after the core request; the late core result must be dropped.
    core_lat = 6;
    @(negedge clk);
    start_i = 1'b1; mode_i = 1'b1; key_i = 64'hCAFEF00DCAFEF00D; iv_i = 64'h1; data_i = 64'h2; valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0; start_i = 1'b0;
    @(posedge clk);
    #1 reset_i = 1'b1;
    @(posedge clk);
    #1 reset_i = 1'b0;
    m_chain = '0; m_key = '0; m_mode = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (valid_o) saw = 1'b1;
    end
    chk("reset drops result", 64'(saw), 64'h0);
    check_reset_state("post-reset");

    core_lat = 3;
    begin
      logic [63:0] k, d;
      k = {$urandom, $urandom}; d = {$urandom, $urandom};
      model_blk(1'b1, 1'b0, k, 64'h0, d, exp);
      xfer(1'b1, 1'b0, k, 64'h0, d, res, lat, busy_ok, req_ok, kobs, mobs);
      chk("after reset data_o", res, exp);
    end

    // Spurious core valid in IDLE: no output, chain untouched.
    @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (valid_o) saw = 1'b1;
    end
    chk("spurious valid_o", 64'(saw), 64'h0);
    begin
      logic [63:0] d;
      d = {$urandom, $urandom};
      model_blk(1'b0, 1'b1, '0, '0, d, exp);
      xfer(1'b0, 1'b1, 64'hFFFF, 64'h0, d, res, lat, busy_ok, req_ok, kobs, mobs);
      chk("spurious chain kept", res, exp);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
